// File: rtl/bsg_age_arbiter.sv
// Age-aware round-robin arbiter: aged requesters win over young ones, and
// rotation within a class starts just after the last granted index.
module bsg_age_arbiter #(
  parameter int inputs_p = 4
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                ready_i,
  input  logic [inputs_p-1:0] ts_i,
  input  logic [inputs_p-1:0] reqs_i,
  output logic [inputs_p-1:0] grants_o
);

  localparam int lg_inputs_lp = (inputs_p > 1) ? $clog2(inputs_p) : 1;
  localparam logic [lg_inputs_lp-1:0] last_idx_lp = lg_inputs_lp'(inputs_p - 1);

  logic [lg_inputs_lp-1:0] last_r;
  logic [lg_inputs_lp-1:0] winner;
  logic [inputs_p-1:0]     old_v;
  logic [inputs_p-1:0]     cand_v;
  logic                    found;
  int                      idx;

  always_comb begin
    old_v  = reqs_i & ts_i;
    cand_v = (|old_v) ? old_v : reqs_i;
    found  = 1'b0;
    winner = last_r;
    idx    = 0;
    // last_r <= inputs_p-1, so one conditional subtract keeps idx in range
    for (int off = 1; off <= inputs_p; off++) begin
      idx = int'(last_r) + off;
      if (idx >= inputs_p) idx = idx - inputs_p;
      if (!found && cand_v[idx]) begin
        found  = 1'b1;
        winner = lg_inputs_lp'(idx);
      end
    end
    grants_o = '0;
    if (ready_i && !reset_i && found) grants_o[winner] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i)        last_r <= last_idx_lp;
    else if (|grants_o) last_r <= winner;
  end

endmodule

// File: tb/tb_bsg_age_arbiter.sv
// Bench for bsg_age_arbiter: four widths checked every cycle against a
// queue-free index model, plus directed literal sequences and fairness counts.
module tb_bsg_age_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       ready;
  logic [9:0] reqs;
  logic [9:0] ts;
  logic [3:0] g4;
  logic [2:0] g3;
  logic [0:0] g1;
  logic [9:0] g10;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bsg_age_arbiter #(.inputs_p(4)) dut4 (
    .clk_i(clk), .reset_i(reset), .ready_i(ready),
    .ts_i(ts[3:0]), .reqs_i(reqs[3:0]), .grants_o(g4));
  bsg_age_arbiter #(.inputs_p(3)) dut3 (
    .clk_i(clk), .reset_i(reset), .ready_i(ready),
    .ts_i(ts[2:0]), .reqs_i(reqs[2:0]), .grants_o(g3));
  bsg_age_arbiter #(.inputs_p(1)) dut1 (
    .clk_i(clk), .reset_i(reset), .ready_i(ready),
    .ts_i(ts[0:0]), .reqs_i(reqs[0:0]), .grants_o(g1));
  bsg_age_arbiter #(.inputs_p(10)) dut10 (
    .clk_i(clk), .reset_i(reset), .ready_i(ready),
    .ts_i(ts), .reqs_i(reqs), .grants_o(g10));

  // Winner index from the arbitration rules, or -1 when nothing is granted.
  function automatic int exp_idx(int n, int ptr, logic [9:0] r, logic [9:0] t,
                                 logic rdy, logic rs);
    logic [10:0] mask;
    logic [9:0]  old_v;
    logic [9:0]  cand;
    mask  = (11'd1 << n) - 11'd1;
    old_v = r & t & mask[9:0];
    cand  = (old_v != 0) ? old_v : (r & mask[9:0]);
    if (rs || !rdy || cand == 0) return -1;
    for (int off = 1; off <= n; off++) begin
      int i;
      i = (ptr + off) % n;
      if (cand[i]) return i;
    end
    return -1;
  endfunction

  int nn  [4] = '{4, 3, 1, 10};
  int ptr [4] = '{3, 2, 0, 9};
  int nxt [4];

  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        int e;
        logic [9:0] ev;
        logic [9:0] act;
        e  = exp_idx(nn[k], ptr[k], reqs, ts, ready, reset);
        ev = (e < 0) ? 10'd0 : (10'd1 << e);
        case (k)
          0:       act = {6'd0, g4};
          1:       act = {7'd0, g3};
          2:       act = {9'd0, g1};
          default: act = g10;
        endcase
        tests++;
        if (act !== ev) begin
          fails++;
          $display("FAIL model_n%0d t=%0t got %b want %b", nn[k], $time, act, ev);
        end
        nxt[k] = reset ? nn[k] - 1 : ((e >= 0) ? e : ptr[k]);
      end
      @(posedge clk);
      ptr = nxt;
    end
  end

  task automatic chk(string nm, logic [9:0] act, logic [9:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0t got %b want %b", nm, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt [4];
    int pc;
    int lo;
    reset = 1'b1; ready = 1'b1; reqs = 10'h3ff; ts = 10'h000;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); chk("reset_gate", {6'd0, g4}, 10'd0);
      tick();
    end
    reset = 1'b0;
    reqs  = 10'h00f;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("rr4", {6'd0, g4}, 10'd1 << (c % 4));
      chk("rr3_wrap", {7'd0, g3}, 10'd1 << (c % 3));
      chk("rr1", {9'd0, g1}, 10'd1);
      tick();
    end
    ts = 10'b0100;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); chk("aged_single", {6'd0, g4}, 10'b0100);
      tick();
    end
    ts = 10'b1010;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); chk("aged_pair", {6'd0, g4}, (c % 2 == 0) ? 10'b1000 : 10'b0010);
      tick();
    end
    ts = 10'd0; ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); chk("ready_low", {6'd0, g4}, 10'd0);
      tick();
    end
    ready = 1'b1;
    @(negedge clk); chk("ptr_held", {6'd0, g4}, 10'b0100);
    tick();
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); chk("mid_reset", {6'd0, g4}, 10'd0);
      tick();
    end
    reset = 1'b0;
    @(negedge clk); chk("after_reset", {6'd0, g4}, 10'b0001);
    tick();

    for (int p = 0; p < 16; p++) begin
      reqs = 10'(p); ts = 10'd0; ready = 1'b1;
      cnt = '{0, 0, 0, 0};
      pc = 0;
      for (int i = 0; i < 4; i++) if (p[i]) pc++;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        for (int i = 0; i < 4; i++) cnt[i] += int'(g4[i]);
        tick();
      end
      ready = 1'b0;
      @(negedge clk); chk("sweep_gap", {6'd0, g4}, 10'd0);
      tick();
      lo = (pc > 0) ? 8 / pc : 0;
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (p[i] ? (cnt[i] < lo || cnt[i] > lo + 1) : (cnt[i] != 0)) begin
          fails++;
          $display("FAIL fair p=%b line=%0d got %0d want %0d..%0d", 4'(p), i, cnt[i],
                   p[i] ? lo : 0, p[i] ? lo + 1 : 0);
        end
      end
    end

    for (int c = 0; c < 1500; c++) begin
      reset = ($urandom_range(0, 31) == 0);
      ready = ($urandom_range(0, 3) != 0);
      reqs  = 10'($urandom);
      ts    = 10'($urandom & $urandom);
      @(negedge clk);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
